// File: rtl/sequenciador_linha_param_pkg.sv
// Shared definitions for the parametrised bottling line sequencer: state encoding and
// default batch sizing.
package sequenciador_linha_param_pkg;

    localparam int unsigned ESTADO_W         = 4;
    localparam int unsigned LOTE_PADRAO      = 12;
    localparam int unsigned MAX_LOTES_PADRAO = 99;

    typedef enum logic [ESTADO_W-1:0] {
        IDLE     = 4'd0,
        MOVER    = 4'd1,
        ESPERA   = 4'd2,
        EXECUTAR = 4'd3,
        DECIDIR  = 4'd4,
        DESCARTE = 4'd5,
        FINAL    = 4'd6,
        CONTAR   = 4'd7,
        ERRO     = 4'd8
    } estado_t;

endpackage

// File: rtl/sequenciador_linha_param_watchdog.sv
// Per-phase cycle watchdog for the line sequencer; instantiated only when WATCHDOG_SEQ_EN
// is defined. expirado rises after 'limit' consecutive enabled cycles without a clear.
module temporizador_watchdog #(
    parameter int unsigned LIMITE_MAX = 50000
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             clear,
    input  logic                             enable,
    input  logic [$clog2(LIMITE_MAX+1)-1:0]  limit,
    output logic                             expirado
);

    localparam int unsigned CNT_WD = $clog2(LIMITE_MAX + 1);

    logic [CNT_WD-1:0] cnt;

    // Saturating counter; expiry flag only survives while the phase is unchanged
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt      <= '0;
            expirado <= 1'b0;
        end else begin
            if (enable && cnt != limit) begin
                cnt <= cnt + CNT_WD'(1);
            end
            expirado <= enable && (cnt == limit - CNT_WD'(1));
        end
    end

endmodule

// File: rtl/sequenciador_linha_param.sv
// Bottling line master sequencer: moves one bottle through N_ESTACOES stations, QC decision,
// reject/exit and batch counting. Define WATCHDOG_SEQ_EN to add the per-phase timeout (ERRO).
module sequenciador_linha_param
    import sequenciador_linha_param_pkg::*;
#(
    parameter int unsigned N_ESTACOES     = 3,
    parameter int unsigned LOTE           = LOTE_PADRAO,
    parameter int unsigned MAX_LOTES      = MAX_LOTES_PADRAO,
    parameter int unsigned TIMEOUT_CICLOS = 50000,
    parameter int unsigned CNT_W          = 7
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [N_ESTACOES-1:0]         sensor_estacao,
    input  logic [N_ESTACOES-1:0]         bloqueio_estacao,
    input  logic [N_ESTACOES-1:0]         estacao_concluida,
    input  logic                          garrafa_aprovada,
    input  logic                          sensor_descarte,
    input  logic                          sensor_final,
    output logic                          motor_ativo,
    output logic [N_ESTACOES-1:0]         cmd_estacao,
    output logic                          descarte_ativo,
    output logic                          incrementar_lote,
    output logic [CNT_W-1:0]              garrafas_no_lote,
    output logic [CNT_W-1:0]              contador_lotes,
    output logic                          erro_timeout,
    output logic [$clog2(N_ESTACOES)-1:0] estacao_erro
);

    localparam int unsigned IDX_W = $clog2(N_ESTACOES);
    localparam logic [IDX_W-1:0] ULTIMA = IDX_W'(N_ESTACOES - 1);

    estado_t               state, state_d;
    logic [IDX_W-1:0]      idx, idx_d;
    logic                  aprovado, aprovado_d;
    logic                  expirado;

    logic                  motor_d;
    logic [N_ESTACOES-1:0] cmd_d;
    logic                  descarte_d;
    logic                  incrementar_d;
    logic [CNT_W-1:0]      garrafas_d;
    logic [CNT_W-1:0]      lotes_d;
    logic                  erro_d;
    logic [IDX_W-1:0]      estacao_erro_d;

`ifdef WATCHDOG_SEQ_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CICLOS + 1);

    logic wd_clear_c;
    logic wd_enable_c;

    assign wd_clear_c  = (state_d != state);
    assign wd_enable_c = (state == MOVER) || (state == EXECUTAR) ||
                         (state == DESCARTE) || (state == FINAL);

    temporizador_watchdog #(
        .LIMITE_MAX (TIMEOUT_CICLOS)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clear    (wd_clear_c),
        .enable   (wd_enable_c),
        .limit    (WD_W'(TIMEOUT_CICLOS)),
        .expirado (expirado)
    );
`else
    assign expirado = 1'b0;
`endif

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            idx              <= '0;
            aprovado         <= 1'b0;
            motor_ativo      <= 1'b0;
            cmd_estacao      <= '0;
            descarte_ativo   <= 1'b0;
            incrementar_lote <= 1'b0;
            garrafas_no_lote <= '0;
            contador_lotes   <= '0;
            erro_timeout     <= 1'b0;
            estacao_erro     <= '0;
        end else begin
            state            <= state_d;
            idx              <= idx_d;
            aprovado         <= aprovado_d;
            motor_ativo      <= motor_d;
            cmd_estacao      <= cmd_d;
            descarte_ativo   <= descarte_d;
            incrementar_lote <= incrementar_d;
            garrafas_no_lote <= garrafas_d;
            contador_lotes   <= lotes_d;
            erro_timeout     <= erro_d;
            estacao_erro     <= estacao_erro_d;
        end
    end

    // Next state; outputs are decoded from the next state so they register with it
    always_comb begin
        state_d       = state;
        idx_d         = idx;
        aprovado_d    = aprovado;
        garrafas_d    = garrafas_no_lote;
        lotes_d       = contador_lotes;
        descarte_d    = 1'b0;
        incrementar_d = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_d = MOVER;
                    idx_d   = '0;
                end
            end
            MOVER: begin
                if (expirado)                 state_d = ERRO;
                else if (sensor_estacao[idx]) state_d = ESPERA;
            end
            ESPERA: begin
                if (!bloqueio_estacao[idx]) state_d = EXECUTAR;
            end
            EXECUTAR: begin
                if (expirado) begin
                    state_d = ERRO;
                end else if (estacao_concluida[idx]) begin
                    if (idx == ULTIMA) begin
                        aprovado_d = garrafa_aprovada;
                        state_d    = DECIDIR;
                    end else begin
                        idx_d   = idx + IDX_W'(1);
                        state_d = MOVER;
                    end
                end
            end
            DECIDIR: begin
                state_d = aprovado ? FINAL : DESCARTE;
            end
            DESCARTE: begin
                if (expirado) begin
                    state_d = ERRO;
                end else if (sensor_descarte) begin
                    descarte_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            FINAL: begin
                if (expirado)          state_d = ERRO;
                else if (sensor_final) state_d = CONTAR;
            end
            CONTAR: begin
                if (garrafas_no_lote == CNT_W'(LOTE - 1)) begin
                    garrafas_d    = '0;
                    incrementar_d = 1'b1;
                    lotes_d       = (contador_lotes == CNT_W'(MAX_LOTES)) ?
                                    '0 : contador_lotes + CNT_W'(1);
                end else begin
                    garrafas_d = garrafas_no_lote + CNT_W'(1);
                end
                state_d = IDLE;
            end
            ERRO: begin
                if (start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        motor_d        = (state_d == MOVER) || (state_d == DESCARTE) || (state_d == FINAL);
        cmd_d          = (state_d == EXECUTAR) ? (N_ESTACOES'(1) << idx_d) : '0;
        erro_d         = (state_d == ERRO);
        estacao_erro_d = (state_d == ERRO) ? idx_d : '0;
    end

endmodule

// File: tb/tb_sequenciador_linha_param.sv
// Directed self-checking bench for sequenciador_linha_param (N=3, LOTE=12, MAX_LOTES=99,
// TIMEOUT_CICLOS=100); the timeout scenario runs when WATCHDOG_SEQ_EN is defined.
module tb_sequenciador_linha_param;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] sensor_estacao;
    logic [2:0] bloqueio_estacao;
    logic [2:0] estacao_concluida;
    logic       garrafa_aprovada;
    logic       sensor_descarte;
    logic       sensor_final;
    logic       motor_ativo;
    logic [2:0] cmd_estacao;
    logic       descarte_ativo;
    logic       incrementar_lote;
    logic [6:0] garrafas_no_lote;
    logic [6:0] contador_lotes;
    logic       erro_timeout;
    logic [1:0] estacao_erro;

    int n_cmp = 0;
    int n_err = 0;
    int pulsos;

    sequenciador_linha_param #(
        .N_ESTACOES     (3),
        .LOTE           (12),
        .MAX_LOTES      (99),
        .TIMEOUT_CICLOS (100),
        .CNT_W          (7)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .sensor_estacao    (sensor_estacao),
        .bloqueio_estacao  (bloqueio_estacao),
        .estacao_concluida (estacao_concluida),
        .garrafa_aprovada  (garrafa_aprovada),
        .sensor_descarte   (sensor_descarte),
        .sensor_final      (sensor_final),
        .motor_ativo       (motor_ativo),
        .cmd_estacao       (cmd_estacao),
        .descarte_ativo    (descarte_ativo),
        .incrementar_lote  (incrementar_lote),
        .garrafas_no_lote  (garrafas_no_lote),
        .contador_lotes    (contador_lotes),
        .erro_timeout      (erro_timeout),
        .estacao_erro      (estacao_erro)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Walks stations 0..2 from MOVER(0); station bloq_idx is held blocked for bloq_ciclos
    task automatic run_stations(input logic aprov, input int bloq_idx, input int bloq_ciclos);
        logic [2:0] oh;
        for (int i = 0; i < 3; i++) begin
            oh = 3'b001 << i;
            if (i == bloq_idx) bloqueio_estacao = oh;
            sensor_estacao = oh;
            tick();
            sensor_estacao = 3'b000;
            chk("espera_motor", motor_ativo, 0);
            chk("espera_cmd", cmd_estacao, 0);
            if (i == bloq_idx) begin
                repeat (bloq_ciclos) tick();
                chk("bloq_cmd", cmd_estacao, 0);
                chk("bloq_motor", motor_ativo, 0);
                chk("bloq_erro", erro_timeout, 0);
                bloqueio_estacao = 3'b000;
            end
            tick();
            chk("exec_cmd", cmd_estacao, oh);
            chk("exec_motor", motor_ativo, 0);
            estacao_concluida = ~oh;
            tick();
            chk("done_outra_estacao", cmd_estacao, oh);
            estacao_concluida = oh;
            garrafa_aprovada  = (i == 2) ? aprov : ~aprov;
            tick();
            estacao_concluida = 3'b000;
            garrafa_aprovada  = ~aprov;
            chk("done_cmd", cmd_estacao, 0);
            chk("done_motor", motor_ativo, (i < 2) ? 1 : 0);
        end
    endtask

    task automatic exit_final(input int exp_garrafas);
        tick();
        chk("final_motor", motor_ativo, 1);
        sensor_final = 1'b1;
        tick();
        sensor_final = 1'b0;
        chk("contar_motor", motor_ativo, 0);
        tick();
        chk("garrafas", garrafas_no_lote, exp_garrafas);
        chk("incr_zero", incrementar_lote, 0);
    endtask

    // Approved bottle with every sensor/done held high: back in IDLE 13 edges after start
    task automatic auto_bottle();
        sensor_estacao    = 3'b111;
        estacao_concluida = 3'b111;
        garrafa_aprovada  = 1'b1;
        sensor_final      = 1'b1;
        pulse_start();
        repeat (12) tick();
        if (incrementar_lote) pulsos++;
    endtask

    task automatic clear_inputs();
        start = 0; sensor_estacao = 0; bloqueio_estacao = 0; estacao_concluida = 0;
        garrafa_aprovada = 0; sensor_descarte = 0; sensor_final = 0;
    endtask

    initial begin
        int waited;
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_motor", motor_ativo, 0);
        chk("rst_cmd", cmd_estacao, 0);
        chk("rst_descarte", descarte_ativo, 0);
        chk("rst_incr", incrementar_lote, 0);
        chk("rst_garrafas", garrafas_no_lote, 0);
        chk("rst_lotes", contador_lotes, 0);
        chk("rst_erro", erro_timeout, 0);

        // Approved bottle through all stations
        tick();
        chk("idle_motor", motor_ativo, 0);
        pulse_start();
        chk("mover_motor", motor_ativo, 1);
        chk("mover_cmd", cmd_estacao, 0);
        repeat (3) tick();
        chk("mover_hold", motor_ativo, 1);
        run_stations(1'b1, -1, 0);
        exit_final(1);

        // Rejected bottle
        pulse_start();
        run_stations(1'b0, -1, 0);
        tick();
        chk("descarte_motor", motor_ativo, 1);
        chk("descarte_pre", descarte_ativo, 0);
        sensor_descarte = 1'b1;
        tick();
        sensor_descarte = 1'b0;
        chk("descarte_pulse", descarte_ativo, 1);
        chk("descarte_motor_off", motor_ativo, 0);
        tick();
        chk("descarte_end", descarte_ativo, 0);
        chk("descarte_garrafas", garrafas_no_lote, 1);

        // Station 1 blocked for 500 cycles
        pulse_start();
        run_stations(1'b1, 1, 500);
        exit_final(2);

        // Batch completion and batch counter wrap
        pulsos = 0;
        repeat (9) auto_bottle();
        chk("lote_11", garrafas_no_lote, 11);
        chk("lote_sem_pulso", pulsos, 0);
        auto_bottle();
        chk("lote_incr", incrementar_lote, 1);
        chk("lote_garrafas0", garrafas_no_lote, 0);
        chk("lote_lotes1", contador_lotes, 1);
        tick();
        chk("lote_incr_1ciclo", incrementar_lote, 0);
        pulsos = 0;
        repeat (98 * 12) auto_bottle();
        chk("lotes_99", contador_lotes, 99);
        chk("pulsos_98", pulsos, 98);
        repeat (11) auto_bottle();
        chk("wrap_pre", contador_lotes, 99);
        auto_bottle();
        chk("wrap_incr", incrementar_lote, 1);
        chk("wrap_lotes", contador_lotes, 0);
        chk("wrap_garrafas", garrafas_no_lote, 0);
        clear_inputs();
        tick();

`ifdef WATCHDOG_SEQ_EN
        // Done withheld at station 2 until the watchdog fires
        sensor_estacao    = 3'b111;
        estacao_concluida = 3'b011;
        pulse_start();
        waited = 0;
        while (!erro_timeout && waited < 400) begin
            tick();
            waited++;
        end
        chk("wd_erro", erro_timeout, 1);
        chk("wd_nao_cedo", (waited >= 100) ? 1 : 0, 1);
        chk("wd_idx", estacao_erro, 2);
        chk("wd_motor", motor_ativo, 0);
        chk("wd_cmd", cmd_estacao, 0);
        chk("wd_descarte", descarte_ativo, 0);
        repeat (5) tick();
        chk("wd_sticky", erro_timeout, 1);
        clear_inputs();
        pulse_start();
        chk("wd_clear", erro_timeout, 0);
        chk("wd_idx_clear", estacao_erro, 0);
        chk("wd_idle_motor", motor_ativo, 0);
        chk("wd_lotes_kept", contador_lotes, 0);
`else
        // Without the watchdog a stuck station just waits
        sensor_estacao    = 3'b111;
        estacao_concluida = 3'b011;
        pulse_start();
        waited = 300;
        repeat (waited) tick();
        chk("sem_wd_erro", erro_timeout, 0);
        chk("sem_wd_cmd", cmd_estacao, 3'b100);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("sem_wd_reset_cmd", cmd_estacao, 0);
        clear_inputs();
`endif

        // Reset during MOVER aborts and clears counters
        auto_bottle();
        clear_inputs();
        chk("pre_rst_garrafas", garrafas_no_lote, 1);
        pulse_start();
        chk("pre_rst_motor", motor_ativo, 1);
        reset = 1'b1;
        tick();
        chk("rst_mover_motor", motor_ativo, 0);
        chk("rst_mover_garrafas", garrafas_no_lote, 0);
        reset = 1'b0;
        tick();
        tick();
        chk("pos_rst_idle", motor_ativo, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
